// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and the datapath (slave).
interface mini_src_control_unit_if;
   logic [31:0] IR;
   logic        mem_ready;
   logic [4:0]  BusDataSelect;
   logic [3:0]  GP_addr;
   logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
   logic        incPC;
   logic        MDR_read;
   logic [3:0]  ALU_op;
   logic        run;
   logic        illegal;

   modport master (
      input  IR, mem_ready,
      output BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
             incPC, MDR_read, ALU_op, run, illegal
   );

   modport slave (
      output IR, mem_ready,
      input  BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
             incPC, MDR_read, ALU_op, run, illegal
   );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired fetch/execute sequencer for the Mini SRC datapath.
// Define CU_MULDIV_EN to compile in the mul/div sequences (state T6).
module mini_src_control_unit (
   input logic                     clock,
   input logic                     clear,
   mini_src_control_unit_if.master cu
);

   localparam logic [4:0] BusHi  = 5'b10000;
   localparam logic [4:0] BusLo  = 5'b10001;
   localparam logic [4:0] BusZhi = 5'b10010;
   localparam logic [4:0] BusZlo = 5'b10011;
   localparam logic [4:0] BusPc  = 5'b10100;
   localparam logic [4:0] BusMdr = 5'b10101;
   localparam logic [4:0] BusC   = 5'b10110;

   typedef enum logic [3:0] {
      StRst, StT0, StT1, StT2, StT3, StT4, StT5,
`ifdef CU_MULDIV_EN
      StT6,
`endif
      StHalt
   } state_e;

   state_e state_q, state_d;
   logic   illegal_q;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_imm, is_md, is_negnot, is_mf, is_nop, is_halt, is_legal;
   logic [3:0] alu_sel;

   assign opcode = cu.IR[31:27];
   assign ra     = cu.IR[26:23];
   assign rb     = cu.IR[22:19];
   assign rc     = cu.IR[18:15];

   assign is_alu    = (opcode >= 5'd3) && (opcode <= 5'd11);
   assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
`ifdef CU_MULDIV_EN
   assign is_md     = (opcode == 5'd15) || (opcode == 5'd16);
`else
   assign is_md     = 1'b0;
`endif
   assign is_negnot = (opcode == 5'd17) || (opcode == 5'd18);
   assign is_mf     = (opcode == 5'd24) || (opcode == 5'd25);
   assign is_nop    = (opcode == 5'd26);
   assign is_halt   = (opcode == 5'd27);
   assign is_legal  = is_alu | is_imm | is_md | is_negnot | is_mf | is_nop | is_halt;

   always_comb begin
      alu_sel = 4'b0000;
      case (opcode)
         5'd3:  alu_sel = 4'b0010;
         5'd4:  alu_sel = 4'b0011;
         5'd5:  alu_sel = 4'b0000;
         5'd6:  alu_sel = 4'b0001;
         5'd7:  alu_sel = 4'b0100;
         5'd8:  alu_sel = 4'b0101;
         5'd9:  alu_sel = 4'b0110;
         5'd10: alu_sel = 4'b0111;
         5'd11: alu_sel = 4'b1000;
         5'd12: alu_sel = 4'b0010;
         5'd13: alu_sel = 4'b0000;
         5'd14: alu_sel = 4'b0001;
`ifdef CU_MULDIV_EN
         5'd15: alu_sel = 4'b1010;
         5'd16: alu_sel = 4'b1001;
`endif
         5'd17: alu_sel = 4'b1011;
         5'd18: alu_sel = 4'b1100;
         default: alu_sel = 4'b0000;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= StRst;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StT2 && !is_legal) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d          = state_q;
      cu.BusDataSelect = 5'b00000;
      cu.GP_addr       = 4'h0;
      cu.e_PC          = 1'b0;
      cu.e_IR          = 1'b0;
      cu.e_Y           = 1'b0;
      cu.e_Z           = 1'b0;
      cu.e_HI          = 1'b0;
      cu.e_LO          = 1'b0;
      cu.e_MDR         = 1'b0;
      cu.e_MAR         = 1'b0;
      cu.e_GP          = 1'b0;
      cu.incPC         = 1'b0;
      cu.MDR_read      = 1'b0;
      cu.ALU_op        = 4'b0000;
      cu.run           = (state_q != StRst) && (state_q != StHalt);
      cu.illegal       = illegal_q;

      unique case (state_q)
         StRst: state_d = StT0;
         StT0: begin
            cu.BusDataSelect = BusPc;
            cu.e_MAR = 1'b1;
            cu.incPC = 1'b1;
            cu.e_Z   = 1'b1;
            state_d  = StT1;
         end
         StT1: begin
            cu.BusDataSelect = BusZlo;
            cu.e_PC     = 1'b1;
            cu.MDR_read = 1'b1;
            cu.e_MDR    = 1'b1;
            if (cu.mem_ready) state_d = StT2;
         end
         StT2: begin
            cu.BusDataSelect = BusMdr;
            cu.e_IR = 1'b1;
            if (!is_legal || is_halt) state_d = StHalt;
            else if (is_nop)          state_d = StT0;
            else                      state_d = StT3;
         end
         StT3: begin
            state_d = StT4;
            if (is_alu || is_imm) begin
               cu.BusDataSelect = {1'b0, rb};
               cu.e_Y = 1'b1;
            end else if (is_md) begin
               cu.BusDataSelect = {1'b0, ra};
               cu.e_Y = 1'b1;
            end else if (is_negnot) begin
               cu.BusDataSelect = {1'b0, rb};
               cu.ALU_op = alu_sel;
               cu.e_Z    = 1'b1;
            end else begin
               // mfhi/mflo: opcode LSB picks HI (0) or LO (1)
               cu.BusDataSelect = {4'b1000, opcode[0]};
               cu.e_GP    = 1'b1;
               cu.GP_addr = ra;
               state_d    = StT0;
            end
         end
         StT4: begin
            if (is_negnot) begin
               cu.BusDataSelect = BusZlo;
               cu.e_GP    = 1'b1;
               cu.GP_addr = ra;
               state_d    = StT0;
            end else begin
               cu.BusDataSelect = is_imm ? BusC : (is_md ? {1'b0, rb} : {1'b0, rc});
               cu.ALU_op = alu_sel;
               cu.e_Z    = 1'b1;
               state_d   = StT5;
            end
         end
         StT5: begin
            cu.BusDataSelect = BusZlo;
            state_d = StT0;
`ifdef CU_MULDIV_EN
            if (is_md) begin
               cu.e_LO = 1'b1;
               state_d = StT6;
            end else begin
               cu.e_GP    = 1'b1;
               cu.GP_addr = ra;
            end
`else
            cu.e_GP    = 1'b1;
            cu.GP_addr = ra;
`endif
         end
`ifdef CU_MULDIV_EN
         StT6: begin
            cu.BusDataSelect = BusZhi;
            cu.e_HI = 1'b1;
            state_d = StT0;
         end
`endif
         StHalt: state_d = StHalt;
         default: state_d = StRst;
      endcase
   end

endmodule

// File: doc/mini_src_control_unit.md
# mini_src_control_unit

Hardwired control sequencer for the Mini SRC CPU; sits directly upstream of `datapath` and drives every enable, bus-select, register-address and ALU-op input of it. It steps through fetch (T0–T2) and per-opcode execute states, decoding the instruction word fed back from IR. It stalls fetch on a memory-ready handshake and stops in HALT on `halt` or an illegal opcode.

## Interface
Parameters:
- none; bus-select encoding is fixed: 00000–01111 = R0–R15, 10000 HI, 10001 LO, 10010 Zhi, 10011 Zlo, 10100 PC, 10101 MDR, 10110 C sign-extended.

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- IR  in  32  current instruction register from datapath; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
- mem_ready  in  1  memory data valid on Mdatain this cycle
- BusDataSelect  out  5  bus source select
- GP_addr  out  4  GP register write address
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  out  1 each  register load enables
- incPC  out  1  ALU computes bus+1 into Z
- MDR_read  out  1  MDR takes Mdatain instead of bus
- ALU_op  out  4  0000 and, 0001 or, 0010 add, 0011 sub, 0100 ror, 0101 rol, 0110 shr, 0111 shra, 1000 shl, 1001 mul, 1010 div, 1011 neg, 1100 not
- run  out  1  high in every state except RST and HALT
- illegal  out  1  sticky; set when an unsupported opcode is decoded

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. All outputs are Moore, decoded from state and IR.
- RST: all outputs 0. First rising edge after `clear` releases -> T0.
- T0: BusDataSelect=PC, e_MAR, incPC, e_Z.
- T1: BusDataSelect=Zlo, e_PC, MDR_read, e_MDR. Stay in T1 while mem_ready=0.
- T2: BusDataSelect=MDR, e_IR.
- R-format add/sub/and/or/ror/rol/shr/shra/shl (00011–01011):
  - T3: Rb->Y.
  - T4: Rc on bus, ALU_op, e_Z.
  - T5: Zlo->Ra (e_GP, GP_addr=Ra).
  - Then T0.
- addi/andi/ori (01100–01110): same sequence, but T4 drives bus 10110 (C sign-extended) with add/and/or.
- mul/div (10000, 01111):
  - T3: Ra->Y.
  - T4: Rb, ALU_op 1001/1010, e_Z.
  - T5: Zlo->LO (e_LO).
  - T6: Zhi->HI (e_HI).
  - Then T0.
- neg/not (10001/10010):
  - T3: Rb, ALU_op, e_Z.
  - T4: Zlo->Ra.
  - Then T0.
- mfhi/mflo (11000/11001): T3: HI/LO on bus, e_GP, GP_addr=Ra; then T0.
- nop (11010): T2 -> T0.
- halt (11011): T2 -> HALT.
- Any other opcode: T2 -> HALT, set `illegal`.
- HALT: all enables 0, run=0. Only `clear` exits HALT.
- GP_addr is 0 whenever e_GP=0. BusDataSelect is 0 in RST and HALT.

## Timing
- One state per clock. Transitions occur on rising `clock`.
- Cycle counts with mem_ready tied high:
  - R-format and immediate: 6 cycles.
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - mfhi/mflo: 4 cycles.
  - nop: 3 cycles.
- Each cycle mem_ready=0 in T1 adds one cycle. Enables stay asserted for the whole stall.
- IR is sampled combinationally only in T2 and later, after e_IR has loaded it. Decode in T2 uses the IR value present during T2.
- `clear` low at any time forces RST immediately and asynchronously: outputs 0, illegal cleared.

## Configuration
- `CU_MULDIV_EN` defined: mul/div sequences (T5/T6) are compiled in.
- `CU_MULDIV_EN` undefined: opcodes 10000 and 01111 decode as illegal (-> HALT, illegal=1), state T6 is absent, and ALU_op never emits 1001/1010.

## Test plan
- `clear` low, then high; IR=0x2A1B8000 (and R4,R3,R7), mem_ready=1:
  - sequence RST, T0..T5, T0.
  - T3: BusDataSelect=00011.
  - T4: BusDataSelect=00111, ALU_op=0000.
  - T5: BusDataSelect=10011, GP_addr=0100, e_GP=1.
- IR=0x612FFFFD (addi R2,R5,-3) -> T3: bus 00101; T4: bus 10110, ALU_op=0010; T5: GP_addr=0010.
- IR=0x81880000 (mul R3,R1) with `CU_MULDIV_EN` -> T5: e_LO, bus 10011; T6: e_HI, bus 10010. Without the macro -> HALT, illegal=1 after T2.
- mem_ready low for 3 cycles in T1 -> T1 held 4 cycles with e_PC/MDR_read/e_MDR high; T2 follows the cycle after mem_ready rises.
- IR=0xD0000000 (nop) -> T2 to T0. IR=0xD8000000 (halt) -> HALT, run=0, all enables 0 for 10+ cycles.
- `clear` pulsed low mid-T4 -> outputs 0 within the same cycle; after release the restart is RST then T0.
